hilo_muldiv_unit: RTL and testbench
===================================

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO register width; all latencies below are stated for WIDTH=32.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset_n  in  1  asynchronous active-low reset.
REQ-005 Port: start_mult  in  1  begin MULT/MULTU on SrcAE x SrcBE.
REQ-006 Port: start_div  in  1  begin DIV/DIVU on SrcAE / SrcBE.
REQ-007 Port: signed_op  in  1  1 = signed (MULT/DIV), 0 = unsigned; sampled with start.
REQ-008 Port: SrcAE  in  WIDTH  operand A / dividend.
REQ-009 Port: SrcBE  in  WIDTH  operand B / divisor.
REQ-010 Port: mthiE, mtloE  in  1 each  write WdataE into HI / LO.
REQ-011 Port: WdataE  in  WIDTH  MTHI/MTLO data.
REQ-012 Port: mfE  in  2  read select: 00 none, 10 HI, 11 LO, 01 none.
REQ-013 Port: Out  out  WIDTH  read data.
REQ-014 Port: busy  out  1  iterative operation in progress.
REQ-015 Port: stallE  out  1  pipeline must hold the E-stage instruction.

Function
REQ-016 FSM states IDLE, RUN, FIX; reset state IDLE.
REQ-017 IDLE->RUN on a clock edge with start_mult or start_div high; operands, op type and signed_op captured at that edge.
REQ-018 Operation starts: accepted only in IDLE; ignored in RUN/FIX.
REQ-019 RUN: exactly WIDTH cycles, one iteration per cycle; multiply is shift-add on magnitudes, divide is restoring on magnitudes; iteration counter runs 0..WIDTH-1.
REQ-020 RUN->FIX after the WIDTH-th iteration; FIX lasts one cycle, applies sign correction and writes HI/LO at its closing edge, then returns to IDLE.
REQ-021 Latency: start sampled at edge E0; HI/LO updated at edge E33; busy high for exactly 33 cycles (after E0 through E33); new values readable on Out from the cycle after E33.
REQ-022 Multiply: {HI,LO} = full 2*WIDTH-bit product; signed result negated iff the operand signs differ.
REQ-023 Divide: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
REQ-024 Divide by zero: HI = SrcAE, LO = all ones; no other effect.
REQ-025 Signed 0x80000000 / -1: LO = 0x80000000, HI = 0.
REQ-026 Simultaneous start_mult and start_div: multiply performed, divide dropped.
REQ-027 mthiE/mtloE in IDLE write HI/LO at the clock edge; both high in the same cycle write both registers.
REQ-028 mthiE/mtloE while busy: write ignored, stallE asserted.
REQ-029 mthiE/mtloE in the same cycle as an accepted start: the write takes effect, and the result later overwrites it.
REQ-030 Out is combinational from HI/LO per mfE; 00/01 drive 0; there is no bypass, so a same-cycle MT write returns the old value.
REQ-031 stallE = busy AND (mfE[1] OR start_mult OR start_div OR mthiE OR mtloE).

Reset
REQ-032 reset_n low, including mid-operation: FSM to IDLE, HI=0, LO=0, counter and partial registers 0, busy=0, stallE=0, Out=0; any in-flight operation is aborted with no HI/LO write.

Structure
REQ-033 Shared package muldiv_pkg holds the state enum, MF_NONE/MF_HI/MF_LO encodings and the DIV0_LO constant.
REQ-034 Sub-module muldiv_iter holds the per-iteration datapath (shift-add/restoring step, magnitude conversion); hilo_muldiv_unit holds the FSM, the HI/LO registers, the read mux and stall logic.

Verification
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 at E33; busy high exactly 33 cycles.
REQ-036 DIV signed -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; MULT signed -1 x 1 -> HI=LO=0xFFFFFFFF.
REQ-037 DIVU 5 / 0 -> HI=0x00000005, LO=0xFFFFFFFF.
REQ-038 MTHI 0x00001234 in IDLE, then mfE=10 -> Out=0x00001234; mfE=11 during RUN -> stallE=1 until the cycle after E33.
REQ-039 reset_n pulsed low at cycle 10 of a MULT -> busy=0, HI=LO=0, no later write; a fresh start afterwards completes normally.
REQ-040 start_div asserted during RUN -> ignored, stallE=1, first result unaffected.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

    // Iterative engine control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // mfE read-select encodings; 2'b01 reads as none.
    localparam logic [1:0] MF_NONE = 2'b00;
    localparam logic [1:0] MF_HI   = 2'b10;
    localparam logic [1:0] MF_LO   = 2'b11;

    // LO value after a divide by zero (all ones, truncated to WIDTH at use).
    localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/muldiv_iter.sv
// Per-iteration datapath: operand magnitudes, one shift-add or restoring
// divide step, and the final sign correction of the accumulated result.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             op_div,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] mag_a_c,
    output logic [WIDTH-1:0] mag_b_c,
    input  logic [WIDTH-1:0] p_hi,
    input  logic [WIDTH-1:0] p_lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] step_hi_c,
    output logic [WIDTH-1:0] step_lo_c,
    input  logic             neg_hi,
    input  logic             neg_lo,
    input  logic             div0,
    input  logic [WIDTH-1:0] orig_a,
    output logic [WIDTH-1:0] res_hi_c,
    output logic [WIDTH-1:0] res_lo_c
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [2*WIDTH-1:0] prod;

    // Absolute values of the incoming operands for signed operations.
    always_comb begin
        mag_a_c = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
        mag_b_c = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;
    end

    // One iteration: multiplier bits consumed from p_lo LSB-first (multiply),
    // or dividend bits shifted out of p_lo MSB-first into the remainder (divide).
    always_comb begin
        step_hi_c = p_hi;
        step_lo_c = p_lo;
        sum       = '0;
        shifted   = '0;
        if (op_div) begin
            shifted = {p_hi, p_lo[WIDTH-1]};
            if (shifted >= {1'b0, m}) begin
                step_hi_c = WIDTH'(shifted - {1'b0, m});
                step_lo_c = {p_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_c = shifted[WIDTH-1:0];
                step_lo_c = {p_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum       = {1'b0, p_hi} + {1'b0, (p_lo[0] ? m : '0)};
            step_hi_c = sum[WIDTH:1];
            step_lo_c = {sum[0], p_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override applied in the FIX cycle.
    always_comb begin
        prod     = {p_hi, p_lo};
        res_hi_c = p_hi;
        res_lo_c = p_lo;
        if (!op_div) begin
            if (neg_lo) begin
                prod = -prod;
            end
            res_hi_c = prod[2*WIDTH-1:WIDTH];
            res_lo_c = prod[WIDTH-1:0];
        end else if (div0) begin
            res_hi_c = orig_a;
            res_lo_c = WIDTH'(DIV0_LO);
        end else begin
            res_hi_c = neg_hi ? -p_hi : p_hi;
            res_lo_c = neg_lo ? -p_lo : p_lo;
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: FSM, HI/LO registers, read mux, stall.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             mthiE,
    input  logic             mtloE,
    input  logic [WIDTH-1:0] WdataE,
    input  logic [1:0]       mfE,
    output logic [WIDTH-1:0] Out,
    output logic             busy,
    output logic             stallE
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state;
    state_e             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               op_div;
    logic               div0;
    logic               neg_hi;
    logic               neg_lo;
    logic [WIDTH-1:0]   orig_a;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   p_hi;
    logic [WIDTH-1:0]   p_lo;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    logic               start_any;
    logic               op_div_in;
    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Multiply wins when both starts are raised together.
    assign start_any = start_mult | start_div;
    assign op_div_in = start_div & ~start_mult;
    assign accept    = (state == ST_IDLE) && start_any;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .op_div    (accept ? op_div_in : op_div),
        .signed_op (signed_op),
        .src_a     (SrcAE),
        .src_b     (SrcBE),
        .mag_a_c   (mag_a),
        .mag_b_c   (mag_b),
        .p_hi      (p_hi),
        .p_lo      (p_lo),
        .m         (m),
        .step_hi_c (step_hi),
        .step_lo_c (step_lo),
        .neg_hi    (neg_hi),
        .neg_lo    (neg_lo),
        .div0      (div0),
        .orig_a    (orig_a),
        .res_hi_c  (res_hi),
        .res_lo_c  (res_lo)
    );

    // State register; busy is registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
        end
    end

    // Next-state logic: IDLE -> RUN (WIDTH iterations) -> FIX (one cycle) -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_any) state_nxt = ST_RUN;
            ST_RUN:  if (last_iter) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture on accept, then one datapath step per RUN cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            op_div <= 1'b0;
            div0   <= 1'b0;
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
            orig_a <= '0;
            m      <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
        end else if (accept) begin
            cnt    <= '0;
            op_div <= op_div_in;
            div0   <= op_div_in && (SrcBE == '0);
            neg_hi <= signed_op & SrcAE[WIDTH-1];
            neg_lo <= signed_op & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
            orig_a <= SrcAE;
            m      <= op_div_in ? mag_b : mag_a;
            p_hi   <= '0;
            p_lo   <= op_div_in ? mag_a : mag_b;
        end else if (state == ST_RUN) begin
            cnt    <= cnt + CNT_W'(1);
            p_hi   <= step_hi;
            p_lo   <= step_lo;
        end
    end

    // HI/LO: result written at the close of FIX; MT writes only while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_FIX) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (state == ST_IDLE) begin
            if (mthiE) hi <= WdataE;
            if (mtloE) lo <= WdataE;
        end
    end

    // Read mux straight from the registers; no bypass of same-cycle writes.
    always_comb begin
        Out = '0;
        case (mfE)
            MF_HI:   Out = hi;
            MF_LO:   Out = lo;
            default: Out = '0;
        endcase
    end

    assign stallE = busy & (mfE[1] | start_mult | start_div | mthiE | mtloE);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: vector table plus corner sequences.
module tb_hilo_muldiv_unit;

    logic        clk;
    logic        reset_n;
    logic        start_mult;
    logic        start_div;
    logic        signed_op;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        mthiE;
    logic        mtloE;
    logic [31:0] WdataE;
    logic [1:0]  mfE;
    logic [31:0] Out;
    logic        busy;
    logic        stallE;

    typedef struct packed {
        logic        is_div;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t vecs [13];
    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_mult (start_mult),
        .start_div  (start_div),
        .signed_op  (signed_op),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .mthiE      (mthiE),
        .mtloE      (mtloE),
        .WdataE     (WdataE),
        .mfE        (mfE),
        .Out        (Out),
        .busy       (busy),
        .stallE     (stallE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Raise a start for one cycle; returns at the negedge after the sampling edge.
    task automatic drive_start(input logic mul, input logic dv, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic push, input logic [31:0] eh, input logic [31:0] el,
                               input logic mtl, input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        start_mult = mul;
        start_div  = dv;
        signed_op  = sgn;
        SrcAE      = a;
        SrcBE      = b;
        mtloE      = mtl;
        WdataE     = wd;
        if (push) begin
            e.hi = eh;
            e.lo = el;
            sb.push_back(e);
        end
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        mtloE      = 1'b0;
    endtask

    // Count busy cycles (bounded) and optionally require stallE throughout.
    task automatic wait_done(input int exp_cycles, input logic chk_stall);
        int c = 0;
        while (busy === 1'b1 && c < 200) begin
            if (chk_stall) check("stall_while_busy", 32'(stallE), 32'd1);
            c++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(c), 32'(exp_cycles));
    endtask

    // Pop the oldest expectation and compare it with HI and LO via Out.
    task automatic check_result(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            mfE = 2'b10;
            #1;
            check({name, "_hi"}, Out, e.hi);
            mfE = 2'b11;
            #1;
            check({name, "_lo"}, Out, e.lo);
            mfE = 2'b00;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[4]  = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[6]  = '{1'b1, 1'b0, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[7]  = '{1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[9]  = '{1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
        vecs[10] = '{1'b0, 1'b1, 32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[12] = '{1'b1, 1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0002};

        reset_n    = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        signed_op  = 1'b0;
        SrcAE      = '0;
        SrcBE      = '0;
        mthiE      = 1'b0;
        mtloE      = 1'b0;
        WdataE     = '0;
        mfE        = 2'b10;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stallE), 32'd0);
        check("rst_hi", Out, 32'd0);
        mfE = 2'b11;
        #1;
        check("rst_lo", Out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // MTHI in idle: same-cycle read sees old value, next cycle the new one.
        @(negedge clk);
        mthiE  = 1'b1;
        WdataE = 32'h0000_1234;
        mfE    = 2'b10;
        #1;
        check("mthi_no_bypass", Out, 32'd0);
        @(negedge clk);
        mthiE = 1'b0;
        #1;
        check("mthi_read", Out, 32'h0000_1234);
        mfE = 2'b01;
        #1;
        check("mf01_zero", Out, 32'd0);
        @(negedge clk);
        mthiE  = 1'b1;
        mtloE  = 1'b1;
        WdataE = 32'hA5A5_5A5A;
        @(negedge clk);
        mthiE = 1'b0;
        mtloE = 1'b0;
        mfE   = 2'b10;
        #1;
        check("mt_both_hi", Out, 32'hA5A5_5A5A);
        mfE = 2'b11;
        #1;
        check("mt_both_lo", Out, 32'hA5A5_5A5A);
        mfE = 2'b00;

        // Vector table.
        for (int i = 0; i < 13; i++) begin
            drive_start(~vecs[i].is_div, vecs[i].is_div, vecs[i].sgn, vecs[i].a, vecs[i].b,
                        1'b1, vecs[i].exp_hi, vecs[i].exp_lo, 1'b0, 32'd0);
            wait_done(33, 1'b0);
            check_result($sformatf("vec%0d", i));
        end

        // Both starts together: multiply wins.
        drive_start(1'b1, 1'b1, 1'b0, 32'd6, 32'd3, 1'b1, 32'd0, 32'd18, 1'b0, 32'd0);
        wait_done(33, 1'b0);
        check_result("both_starts");

        // MTLO in the accepting cycle lands, then the result overwrites it.
        drive_start(1'b1, 1'b0, 1'b0, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 1'b1, 32'hCAFE_0000);
        mfE = 2'b11;
        #1;
        check("mt_with_start", Out, 32'hCAFE_0000);
        mfE = 2'b00;
        wait_done(33, 1'b0);
        check_result("mt_with_start_result");

        // Start and MTHI while busy are ignored and stall; mfE read stalls until done.
        drive_start(1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1,
                    32'h0000_0001, 32'h0000_0000, 1'b0, 32'd0);
        mfE       = 2'b11;
        start_div = 1'b1;
        mthiE     = 1'b1;
        WdataE    = 32'hDEAD_BEEF;
        SrcAE     = 32'd9;
        SrcBE     = 32'd3;
        #1;
        check("stall_start_busy", 32'(stallE), 32'd1);
        @(negedge clk);
        start_div = 1'b0;
        mthiE     = 1'b0;
        wait_done(32, 1'b1);
        #1;
        check("stall_released", 32'(stallE), 32'd0);
        check_result("busy_ignore");
        @(negedge clk);
        #1;
        check("no_late_op", 32'(busy), 32'd0);

        // Reset mid-multiply aborts without a write; a fresh start completes.
        drive_start(1'b1, 1'b0, 1'b1, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        mfE     = 2'b10;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_stall", 32'(stallE), 32'd0);
        check("midrst_hi", Out, 32'd0);
        mfE = 2'b11;
        #1;
        check("midrst_lo", Out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_lo", Out, 32'd0);
        mfE = 2'b10;
        #1;
        check("postrst_hi", Out, 32'd0);
        mfE = 2'b00;
        drive_start(1'b1, 1'b0, 1'b1, 32'd5, 32'hFFFF_FFF9, 1'b1,
                    32'hFFFF_FFFF, 32'hFFFF_FFDD, 1'b0, 32'd0);
        wait_done(33, 1'b0);
        check_result("after_reset");

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
